// File: rtl/lz77_decoder.sv
// LZ77 token decoder with a shift-register history; outputs are registered.
// Optional LZ77_DEC_OFFSET_CHECK_EN adds a fill counter and sticky err output.
module lz77_decoder #(
   parameter int HIST_DEPTH = 9
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [3:0] offset,
   input  logic [2:0] match_len,
   input  logic [7:0] char_nxt,
   output logic       out_valid,
   output logic [7:0] out_char,
   output logic       finish
`ifdef LZ77_DEC_OFFSET_CHECK_EN
   ,
   output logic       err
`endif
);

   typedef enum logic [1:0] {IDLE, COPY, LIT, DONE} state_t;

   state_t     state_q, state_d;
   logic [3:0] off_q, off_d;
   logic [2:0] cnt_q, cnt_d;
   logic [7:0] chr_q, chr_d;
   logic       out_valid_q, out_valid_d;
   logic [7:0] out_char_q, out_char_d;
   logic       in_ready_q, in_ready_d;
   logic       finish_q, finish_d;
   logic [7:0] hist_q [HIST_DEPTH];
   logic [7:0] hist_d [HIST_DEPTH];
   logic       push;
   logic [3:0] rd_off;
   logic [7:0] rd_char;

`ifdef LZ77_DEC_OFFSET_CHECK_EN
   localparam int FW = $clog2(HIST_DEPTH + 1);
   logic [FW-1:0] fill_q, fill_d;
   logic          err_q, err_d;
`endif

   // Out-of-range offsets fall through to the oldest entry.
   assign rd_off = (state_q == IDLE) ? offset : off_q;

   always_comb begin
      rd_char = hist_q[HIST_DEPTH-1];
      for (int i = 0; i < HIST_DEPTH; i++)
         if (32'(rd_off) == i)
            rd_char = hist_q[i];
   end

   always_comb begin
      state_d     = state_q;
      off_d       = off_q;
      cnt_d       = cnt_q;
      chr_d       = chr_q;
      out_valid_d = 1'b0;
      out_char_d  = out_char_q;
      hist_d      = hist_q;
      push        = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (in_valid) begin
               off_d       = offset;
               chr_d       = char_nxt;
               push        = 1'b1;
               out_valid_d = 1'b1;
               if (match_len != 3'd0) begin
                  out_char_d = rd_char;
                  cnt_d      = match_len - 3'd1;
                  state_d    = COPY;
               end else begin
                  out_char_d = char_nxt;
                  state_d    = LIT;
               end
            end
         end
         COPY: begin
            push        = 1'b1;
            out_valid_d = 1'b1;
            if (cnt_q != 3'd0) begin
               out_char_d = rd_char;
               cnt_d      = cnt_q - 3'd1;
            end else begin
               out_char_d = chr_q;
               state_d    = LIT;
            end
         end
         LIT: begin
            state_d = (chr_q == 8'h24) ? DONE : IDLE;
         end
         DONE: begin
            state_d = DONE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if (push) begin
         hist_d[0] = out_char_d;
         for (int i = 1; i < HIST_DEPTH; i++)
            hist_d[i] = hist_q[i-1];
      end
      in_ready_d = (state_d == IDLE);
      finish_d   = (state_d == DONE);
   end

`ifdef LZ77_DEC_OFFSET_CHECK_EN
   always_comb begin
      fill_d = fill_q;
      err_d  = err_q;
      if (push && 32'(fill_q) < HIST_DEPTH)
         fill_d = fill_q + FW'(1);
      if (state_q == IDLE && in_valid && match_len != 3'd0 &&
          32'(offset) >= 32'(fill_q))
         err_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fill_q <= '0;
         err_q  <= 1'b0;
      end else begin
         fill_q <= fill_d;
         err_q  <= err_d;
      end
   end

   assign err = err_q;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         off_q       <= '0;
         cnt_q       <= '0;
         chr_q       <= '0;
         out_valid_q <= 1'b0;
         out_char_q  <= 8'h00;
         in_ready_q  <= 1'b1;
         finish_q    <= 1'b0;
         hist_q      <= '{default: 8'h00};
      end else begin
         state_q     <= state_d;
         off_q       <= off_d;
         cnt_q       <= cnt_d;
         chr_q       <= chr_d;
         out_valid_q <= out_valid_d;
         out_char_q  <= out_char_d;
         in_ready_q  <= in_ready_d;
         finish_q    <= finish_d;
         hist_q      <= hist_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_char  = out_char_q;
   assign in_ready  = in_ready_q;
   assign finish    = finish_q;

endmodule
